// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//    DEF_DATA_W / DEF_REG_AW : default register data and address widths
//    wb_state_e              : drain-control states for the long-latency buffer
//    wb_entry_t              : one buffered long-latency result {dest, data}
package wb_arb_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_REG_AW = 3;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      FORCE
   } wb_state_e;

   typedef struct packed {
      logic [DEF_REG_AW-1:0] dest;
      logic [DEF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results until they win the
// register-file write port.
//    clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//    push       : write push_data at the clock edge (ignored when full)
//    push_data  : entry to store
//    pop        : drop the head entry at the clock edge (ignored when empty)
//    head       : oldest stored entry (valid when count != 0)
//    count      : number of stored entries
module wb_result_fifo
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  entry_t                       push_data,
   input  logic                         pop,
   output entry_t                       head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   // Pointers wrap at DEPTH rather than at a power of two, so any depth works.
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push = push && (count < CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // Storage needs no reset: count and the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
   // the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order writeback
// stage and a long-latency (mul/div) unit whose results arrive out of band.
//    clk, rst                      : clock, asynchronous active-high reset
//    iss_valid, iss_reg            : long-latency op issued; marks iss_reg busy
//    busy_regs                     : registers still awaiting a long-latency result
//    pipe_wr_en/_reg/_data         : writeback request (highest priority)
//    pipe_stall                    : one-cycle forced stall so a starved result drains
//    lu_valid/_reg/_data, lu_ready : long-latency result handshake into the buffer
//    rf_wr_en/_reg/_data           : registered register-file write
//    buf_count                     : buffered long-latency results
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int REG_AW       = DEF_REG_AW
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         iss_valid,
   input  logic [REG_AW-1:0]            iss_reg,
   output logic [2**REG_AW-1:0]         busy_regs,
   input  logic                         pipe_wr_en,
   input  logic [REG_AW-1:0]            pipe_wr_reg,
   input  logic [DATA_W-1:0]            pipe_wr_data,
   output logic                         pipe_stall,
   input  logic                         lu_valid,
   input  logic [REG_AW-1:0]            lu_reg,
   input  logic [DATA_W-1:0]            lu_data,
   output logic                         lu_ready,
   output logic                         rf_wr_en,
   output logic [REG_AW-1:0]            rf_wr_reg,
   output logic [DATA_W-1:0]            rf_wr_data,
   output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

   localparam int NREG = 2**REG_AW;
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int SW   = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] data;
   } lu_entry_t;

   lu_entry_t        push_data;
   lu_entry_t        head;
   logic             push;
   logic             pipe_grant;
   logic             head_grant;
   logic             last_entry;
   logic [NREG-1:0]  busy_set;
   logic [NREG-1:0]  busy_clr;
   wb_state_e        state;
   wb_state_e        state_next;
   logic [SW-1:0]    starve_cnt;
   logic [SW-1:0]    starve_next;

   // lu_ready looks only at the registered count, so a full buffer refuses a
   // new result even in a cycle where the head is draining.
   assign lu_ready   = (buf_count < CW'(DEPTH));
   assign push       = lu_valid && lu_ready;
   assign push_data  = '{dest: lu_reg, data: lu_data};

   // During a stall the writeback request is ignored, which is what lets the
   // buffered head through unconditionally in FORCE.
   assign pipe_grant = pipe_wr_en && !pipe_stall;
   assign head_grant = !pipe_grant && (buf_count != '0);
   assign last_entry = (buf_count == CW'(1)) && !push;

   assign busy_set   = iss_valid  ? (NREG'(1) << iss_reg)   : '0;
   assign busy_clr   = head_grant ? (NREG'(1) << head.dest) : '0;

   wb_result_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (lu_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (head_grant),
      .head      (head),
      .count     (buf_count)
   );

   // Drain control: count consecutive cycles the buffered head loses to the
   // writeback stage and, on the STARVE_LIMIT-th loss, schedule a stall cycle.
   always_comb begin
      state_next  = state;
      starve_next = starve_cnt;
      case (state)
         IDLE: begin
            if (push) begin
               state_next = PEND;
            end
         end
         PEND: begin
            if (head_grant) begin
               starve_next = '0;
               if (last_entry) begin
                  state_next = IDLE;
               end
            end else begin
               starve_next = starve_cnt + 1'b1;
               if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                  state_next = FORCE;
               end
            end
         end
         FORCE: begin
            starve_next = '0;
            state_next  = last_entry ? IDLE : PEND;
         end
         default: begin
            state_next  = IDLE;
            starve_next = '0;
         end
      endcase
   end

   // State, starvation counter and the registered stall flag, which is high
   // exactly for the cycle spent in FORCE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         pipe_stall <= 1'b0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         pipe_stall <= (state_next == FORCE);
      end
   end

   // Registered write port; address and data hold their last value when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wr_en   <= 1'b0;
         rf_wr_reg  <= '0;
         rf_wr_data <= '0;
      end else begin
         rf_wr_en <= pipe_grant || head_grant;
         if (pipe_grant) begin
            rf_wr_reg  <= pipe_wr_reg;
            rf_wr_data <= pipe_wr_data;
         end else if (head_grant) begin
            rf_wr_reg  <= head.dest;
            rf_wr_data <= head.data;
         end
      end
   end

   // Pending-result scoreboard: a bit clears on the edge its result is
   // written; a re-issue of the same register in that cycle keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_regs <= '0;
      end else begin
         busy_regs <= (busy_regs & ~busy_clr) | busy_set;
      end
   end

   // Protocol violations the issue logic and long-latency unit must never make.
   a_iss_busy: assert property (@(posedge clk) disable iff (rst)
      iss_valid |-> (!busy_regs[iss_reg] || busy_clr[iss_reg]));
   a_pipe_busy: assert property (@(posedge clk) disable iff (rst)
      pipe_wr_en |-> !busy_regs[pipe_wr_reg]);
   a_lu_overflow: assert property (@(posedge clk) disable iff (rst)
      lu_valid |-> lu_ready);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [2:0]  iss_reg;
   logic [7:0]  busy_regs;
   logic        pipe_wr_en;
   logic [2:0]  pipe_wr_reg;
   logic [15:0] pipe_wr_data;
   logic        pipe_stall;
   logic        lu_valid;
   logic [2:0]  lu_reg;
   logic [15:0] lu_data;
   logic        lu_ready;
   logic        rf_wr_en;
   logic [2:0]  rf_wr_reg;
   logic [15:0] rf_wr_data;
   logic [1:0]  buf_count;

   int compared   = 0;
   int mismatched = 0;

   wb_port_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT),
      .DATA_W       (16),
      .REG_AW       (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .iss_valid    (iss_valid),
      .iss_reg      (iss_reg),
      .busy_regs    (busy_regs),
      .pipe_wr_en   (pipe_wr_en),
      .pipe_wr_reg  (pipe_wr_reg),
      .pipe_wr_data (pipe_wr_data),
      .pipe_stall   (pipe_stall),
      .lu_valid     (lu_valid),
      .lu_reg       (lu_reg),
      .lu_data      (lu_data),
      .lu_ready     (lu_ready),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_reg    (rf_wr_reg),
      .rf_wr_data   (rf_wr_data),
      .buf_count    (buf_count)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Vector record: one cycle of inputs and the outputs expected after its edge
   typedef struct {
      logic        iv;
      logic [2:0]  ir;
      logic        pe;
      logic [2:0]  pr;
      logic [15:0] pd;
      logic        lv;
      logic [2:0]  lr;
      logic [15:0] ld;
      logic        e_en;
      logic [2:0]  e_reg;
      logic [15:0] e_data;
      logic [7:0]  e_busy;
      logic [1:0]  e_cnt;
      logic        e_stall;
      logic        e_ready;
   } vec_t;

   typedef struct {
      logic [2:0]  rg;
      logic [15:0] d;
   } ent_t;

   vec_t        vecs[16];

   // Reference model state for the random phase
   ent_t        m_q[$];
   logic [2:0]  m_pending[$];
   logic [7:0]  m_busy;
   bit          m_stall;
   int          m_denied;
   logic        m_rf_en;
   logic [2:0]  m_rf_reg;
   logic [15:0] m_rf_data;

   function automatic vec_t mkVec(int iv, int ir, int pe, int pr, int pd, int lv, int lr, int ld,
                                  int een, int ereg, int edata, int ebusy, int ecnt, int estall, int erdy);
      vec_t v;
      v.iv = 1'(iv);       v.ir = 3'(ir);
      v.pe = 1'(pe);       v.pr = 3'(pr);      v.pd = 16'(pd);
      v.lv = 1'(lv);       v.lr = 3'(lr);      v.ld = 16'(ld);
      v.e_en = 1'(een);    v.e_reg = 3'(ereg); v.e_data = 16'(edata);
      v.e_busy = 8'(ebusy); v.e_cnt = 2'(ecnt);
      v.e_stall = 1'(estall); v.e_ready = 1'(erdy);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic iv, input logic [2:0] ir,
                                input logic pe, input logic [2:0] pr, input logic [15:0] pd,
                                input logic lv, input logic [2:0] lr, input logic [15:0] ld);
      iss_valid = iv;  iss_reg = ir;
      pipe_wr_en = pe; pipe_wr_reg = pr; pipe_wr_data = pd;
      lu_valid = lv;   lu_reg = lr;      lu_data = ld;
      tick();
   endtask

   task automatic idleInputs;
      iss_valid = 0; iss_reg = 0;
      pipe_wr_en = 0; pipe_wr_reg = 0; pipe_wr_data = 0;
      lu_valid = 0; lu_reg = 0; lu_data = 0;
   endtask

   task automatic doReset;
      idleInputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pickFree(input logic excl_en, input logic [2:0] excl, output bit ok, output logic [2:0] r);
      logic [2:0] cand[$];
      for (int i = 0; i < 8; i++) begin
         if (!m_busy[i] && !(excl_en && excl == 3'(i))) cand.push_back(3'(i));
      end
      ok = (cand.size() > 0);
      r  = '0;
      if (ok) r = cand[$urandom_range(0, cand.size() - 1)];
   endtask

   // Advance the reference model by one clock edge using the current inputs
   task automatic modelStep;
      bit   pipe_win;
      bit   next_stall;
      ent_t e;
      pipe_win   = pipe_wr_en && !m_stall;
      next_stall = 0;
      if (pipe_win) begin
         m_rf_en = 1; m_rf_reg = pipe_wr_reg; m_rf_data = pipe_wr_data;
         if (m_q.size() > 0) begin
            m_denied++;
            if (m_denied == STARVE_LIMIT) begin
               next_stall = 1;
               m_denied   = 0;
            end
         end
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         m_rf_en = 1; m_rf_reg = e.rg; m_rf_data = e.d;
         m_busy[e.rg] = 1'b0;
         m_denied = 0;
      end else begin
         m_rf_en = 0;
      end
      if (iss_valid) m_busy[iss_reg] = 1'b1;
      if (lu_valid) m_q.push_back('{lu_reg, lu_data});
      m_stall = next_stall;
   endtask

   initial begin
      int   n;
      bit   ok;
      logic [2:0] r;

      // ---------------- reset state ----------------
      doReset();
      #1;
      checkOutput("reset rf_wr_en",   32'(rf_wr_en),   32'd0);
      checkOutput("reset rf_wr_reg",  32'(rf_wr_reg),  32'd0);
      checkOutput("reset rf_wr_data", 32'(rf_wr_data), 32'd0);
      checkOutput("reset busy_regs",  32'(busy_regs),  32'd0);
      checkOutput("reset buf_count",  32'(buf_count),  32'd0);
      checkOutput("reset pipe_stall", 32'(pipe_stall), 32'd0);
      checkOutput("reset lu_ready",   32'(lu_ready),   32'd1);

      // ---------------- table: idle drain, pipe priority, set/clear collision ----------------
      vecs[0]  = mkVec(1,3, 0,0,0,      0,0,0,       0,0,'h0000, 'h08,0,0,1);
      vecs[1]  = mkVec(0,0, 0,0,0,      0,0,0,       0,0,'h0000, 'h08,0,0,1);
      vecs[2]  = mkVec(0,0, 0,0,0,      1,3,'hBEEF,  0,0,'h0000, 'h08,1,0,1);
      vecs[3]  = mkVec(0,0, 0,0,0,      0,0,0,       1,3,'hBEEF, 'h00,0,0,1);
      vecs[4]  = mkVec(0,0, 0,0,0,      0,0,0,       0,3,'hBEEF, 'h00,0,0,1);
      vecs[5]  = mkVec(1,6, 0,0,0,      0,0,0,       0,3,'hBEEF, 'h40,0,0,1);
      vecs[6]  = mkVec(0,0, 0,0,0,      1,6,'h0066,  0,3,'hBEEF, 'h40,1,0,1);
      vecs[7]  = mkVec(0,0, 1,1,'h0011, 0,0,0,       1,1,'h0011, 'h40,1,0,1);
      vecs[8]  = mkVec(0,0, 1,2,'h0022, 0,0,0,       1,2,'h0022, 'h40,1,0,1);
      vecs[9]  = mkVec(0,0, 0,0,0,      0,0,0,       1,6,'h0066, 'h00,0,0,1);
      vecs[10] = mkVec(0,0, 0,0,0,      0,0,0,       0,6,'h0066, 'h00,0,0,1);
      vecs[11] = mkVec(1,5, 0,0,0,      0,0,0,       0,6,'h0066, 'h20,0,0,1);
      vecs[12] = mkVec(0,0, 0,0,0,      1,5,'h0555,  0,6,'h0066, 'h20,1,0,1);
      vecs[13] = mkVec(1,5, 0,0,0,      0,0,0,       1,5,'h0555, 'h20,0,0,1);
      vecs[14] = mkVec(0,0, 0,0,0,      1,5,'h0AAA,  0,5,'h0555, 'h20,1,0,1);
      vecs[15] = mkVec(0,0, 0,0,0,      0,0,0,       1,5,'h0AAA, 'h00,0,0,1);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].ir, vecs[i].pe, vecs[i].pr, vecs[i].pd,
                       vecs[i].lv, vecs[i].lr, vecs[i].ld);
         checkOutput($sformatf("vec%0d rf_wr_en", i),   32'(rf_wr_en),   32'(vecs[i].e_en));
         checkOutput($sformatf("vec%0d rf_wr_reg", i),  32'(rf_wr_reg),  32'(vecs[i].e_reg));
         checkOutput($sformatf("vec%0d rf_wr_data", i), 32'(rf_wr_data), 32'(vecs[i].e_data));
         checkOutput($sformatf("vec%0d busy_regs", i),  32'(busy_regs),  32'(vecs[i].e_busy));
         checkOutput($sformatf("vec%0d buf_count", i),  32'(buf_count),  32'(vecs[i].e_cnt));
         checkOutput($sformatf("vec%0d pipe_stall", i), 32'(pipe_stall), 32'(vecs[i].e_stall));
         checkOutput($sformatf("vec%0d lu_ready", i),   32'(lu_ready),   32'(vecs[i].e_ready));
      end

      // ---------------- starvation ----------------
      doReset();
      applyStimulus(1,3'd4, 0,3'd0,16'h0, 0,3'd0,16'h0);
      applyStimulus(0,3'd0, 0,3'd0,16'h0, 1,3'd4,16'h4444);
      checkOutput("starve buffered", 32'(buf_count), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(0,3'd0, 1,3'd1,16'(16'h0100 + k), 0,3'd0,16'h0);
         checkOutput($sformatf("starve pipe%0d data", k), 32'(rf_wr_data), 32'(16'h0100 + k));
         checkOutput($sformatf("starve pipe%0d stall", k), 32'(pipe_stall), 32'(k == 4));
      end
      applyStimulus(0,3'd0, 1,3'd1,16'h0105, 0,3'd0,16'h0);
      checkOutput("starve drain reg",   32'(rf_wr_reg),  32'd4);
      checkOutput("starve drain data",  32'(rf_wr_data), 32'h4444);
      checkOutput("starve drain stall", 32'(pipe_stall), 32'd0);
      checkOutput("starve drain busy",  32'(busy_regs),  32'd0);
      applyStimulus(0,3'd0, 1,3'd1,16'h0105, 0,3'd0,16'h0);
      checkOutput("starve replay en",   32'(rf_wr_en),   32'd1);
      checkOutput("starve replay reg",  32'(rf_wr_reg),  32'd1);
      checkOutput("starve replay data", 32'(rf_wr_data), 32'h0105);
      applyStimulus(0,3'd0, 0,3'd0,16'h0, 0,3'd0,16'h0);
      checkOutput("starve idle en", 32'(rf_wr_en), 32'd0);

      // ---------------- full buffer ----------------
      doReset();
      applyStimulus(1,3'd2, 0,3'd0,16'h0, 0,3'd0,16'h0);
      applyStimulus(1,3'd3, 0,3'd0,16'h0, 0,3'd0,16'h0);
      applyStimulus(1,3'd5, 0,3'd0,16'h0, 0,3'd0,16'h0);
      applyStimulus(0,3'd0, 1,3'd0,16'h00AA, 1,3'd2,16'h2222);
      checkOutput("full count1", 32'(buf_count), 32'd1);
      applyStimulus(0,3'd0, 1,3'd0,16'h00AA, 1,3'd3,16'h3333);
      checkOutput("full count2", 32'(buf_count), 32'd2);
      checkOutput("full ready0", 32'(lu_ready),  32'd0);
      n = 0;
      while (!lu_ready && n < 20) begin
         applyStimulus(0,3'd0, 1,3'd0,16'h00AA, 0,3'd0,16'h0);
         n++;
      end
      checkOutput("full held-off cycles", 32'(n), 32'd4);
      checkOutput("full first pop reg",  32'(rf_wr_reg),  32'd2);
      checkOutput("full first pop data", 32'(rf_wr_data), 32'h2222);
      applyStimulus(0,3'd0, 1,3'd0,16'h00AA, 1,3'd5,16'h5555);
      checkOutput("full third accepted", 32'(buf_count), 32'd2);
      applyStimulus(0,3'd0, 0,3'd0,16'h0, 0,3'd0,16'h0);
      checkOutput("full order reg2",  32'(rf_wr_reg),  32'd3);
      checkOutput("full order data2", 32'(rf_wr_data), 32'h3333);
      applyStimulus(0,3'd0, 0,3'd0,16'h0, 0,3'd0,16'h0);
      checkOutput("full order reg3",  32'(rf_wr_reg),  32'd5);
      checkOutput("full order data3", 32'(rf_wr_data), 32'h5555);
      checkOutput("full empty",       32'(buf_count),  32'd0);
      checkOutput("full busy clear",  32'(busy_regs),  32'd0);

      // ---------------- reset mid-burst ----------------
      applyStimulus(1,3'd1, 0,3'd0,16'h0, 0,3'd0,16'h0);
      applyStimulus(1,3'd2, 0,3'd0,16'h0, 0,3'd0,16'h0);
      applyStimulus(0,3'd0, 1,3'd0,16'h0077, 1,3'd1,16'h1111);
      applyStimulus(0,3'd0, 1,3'd0,16'h0078, 1,3'd2,16'h2222);
      checkOutput("midrst pre count", 32'(buf_count), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("midrst buf_count", 32'(buf_count), 32'd0);
      checkOutput("midrst busy_regs", 32'(busy_regs), 32'd0);
      checkOutput("midrst rf_wr_en",  32'(rf_wr_en),  32'd0);
      checkOutput("midrst lu_ready",  32'(lu_ready),  32'd1);
      idleInputs();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0,3'd0, 0,3'd0,16'h0, 0,3'd0,16'h0);
      checkOutput("midrst after rf_wr_en", 32'(rf_wr_en), 32'd0);

      // ---------------- randomized against reference model ----------------
      doReset();
      m_q.delete();
      m_pending.delete();
      m_busy = '0; m_stall = 0; m_denied = 0;
      m_rf_en = 0; m_rf_reg = '0; m_rf_data = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!m_stall) begin
            pipe_wr_en = 0;
            if ($urandom_range(0, 1) == 1) begin
               pickFree(1'b0, 3'd0, ok, r);
               if (ok) begin
                  pipe_wr_en = 1; pipe_wr_reg = r; pipe_wr_data = 16'($urandom);
               end
            end
         end
         iss_valid = 0;
         if ($urandom_range(0, 2) == 0) begin
            pickFree(pipe_wr_en, pipe_wr_reg, ok, r);
            if (ok) begin
               iss_valid = 1; iss_reg = r;
            end
         end
         lu_valid = 0; lu_reg = 3'($urandom); lu_data = 16'($urandom);
         if (m_q.size() < DEPTH && m_pending.size() > 0 && $urandom_range(0, 1) == 1) begin
            lu_valid = 1;
            lu_reg   = m_pending.pop_front();
         end
         modelStep();
         if (iss_valid) m_pending.push_back(iss_reg);
         tick();
         checkOutput("rand rf_wr_en",   32'(rf_wr_en),   32'(m_rf_en));
         checkOutput("rand rf_wr_reg",  32'(rf_wr_reg),  32'(m_rf_reg));
         checkOutput("rand rf_wr_data", 32'(rf_wr_data), 32'(m_rf_data));
         checkOutput("rand busy_regs",  32'(busy_regs),  32'(m_busy));
         checkOutput("rand buf_count",  32'(buf_count),  32'(m_q.size()));
         checkOutput("rand pipe_stall", 32'(pipe_stall), 32'(m_stall));
         checkOutput("rand lu_ready",   32'(lu_ready),   32'(m_q.size() < DEPTH));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port of the 16-bit core and shares it between two writers: the in-order writeback stage (its regData result) and a long-latency unit (multi-cycle multiply/divide) that returns results out of band.
- Buffers long-latency results and tracks destination registers with pending results so the issue stage can block hazards.
- Forces a one-cycle pipeline stall when a buffered result has been starved too long.

Parameters:
DEPTH, 2, long-latency result buffer entries (>=1)
STARVE_LIMIT, 4, consecutive denied cycles before a forced drain (>=1)
DATA_W, 16, register data width
REG_AW, 3, register address width (8 registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
iss_valid  in  1  long-latency op issued this cycle
iss_reg  in  REG_AW  destination of issued long-latency op
busy_regs  out  2**REG_AW  bit i set = register i has a pending long-latency result
pipe_wr_en  in  1  writeback stage requests a register write
pipe_wr_reg  in  REG_AW  writeback destination
pipe_wr_data  in  DATA_W  writeback data (selected regData)
pipe_stall  out  1  registered; writeback must hold and re-present next cycle
lu_valid  in  1  long-latency result valid
lu_reg  in  REG_AW  long-latency result destination
lu_data  in  DATA_W  long-latency result data
lu_ready  out  1  buffer can accept (count < DEPTH)
rf_wr_en  out  1  registered register-file write enable
rf_wr_reg  out  REG_AW  registered write address
rf_wr_data  out  DATA_W  registered write data
buf_count  out  clog2(DEPTH+1)  buffered entries

Behaviour:
- Reset (async, takes effect immediately):
  - rf_wr_en/rf_wr_reg/rf_wr_data = 0, busy_regs = 0, buf_count = 0, pipe_stall = 0, starve_cnt = 0, state IDLE, lu_ready = 1.
  - Reset mid-operation discards buffer contents and pending busy bits.
- Accept: lu_valid && lu_ready pushes {lu_reg, lu_data} at the clock edge. The entry is visible at the buffer head the next cycle; there is no same-cycle bypass.
- lu_ready derives only from the registered count. At full it is 0 even if the head drains that cycle.
- Grant each cycle, with priority in this order:
  - pipe_wr_en && !pipe_stall: writeback wins.
  - Else if buffer non-empty: head wins and is popped.
  - Else no write.
- Output latency: the winner appears on rf_wr_* one cycle after grant; rf_wr_en = 0 on idle cycles, with addr/data held.
- While pipe_stall = 1, pipe_wr_en is ignored. Upstream re-presents the same write next cycle.
- FSM states:
  - IDLE: buffer empty.
    - Goes to PEND on accept.
  - PEND: buffer non-empty.
    - Head granted: starve_cnt = 0; goes to IDLE if the pop empties the buffer with no concurrent push.
    - Head denied: starve_cnt++; when the denied cycle has starve_cnt == STARVE_LIMIT-1, goes to FORCE and pipe_stall = 1 next cycle.
  - FORCE: pipe_stall = 1 for exactly one cycle and the head drains unconditionally.
    - starve_cnt = 0; next state is PEND if entries remain, else IDLE.
- Scoreboard:
  - iss_valid sets busy_regs[iss_reg].
  - Popping a head entry clears busy_regs[head.reg] at the same edge rf_wr_en rises for it.
  - Set and clear of the same bit in one cycle: set wins.
- Illegal, flagged by simulation assertion with no hardware recovery:
  - iss_valid to an already-busy reg.
  - pipe_wr_en to a busy reg.
  - lu_valid while lu_ready = 0.
- Simultaneous accept and pop: count unchanged. Buffer pointers wrap modulo DEPTH.

Decomposition:
- Package wb_arb_pkg: state enum {IDLE, PEND, FORCE}, DATA_W/REG_AW defaults, and the buffer entry struct {reg, data}.
- One natural sub-module: wb_result_fifo, a DEPTH-entry synchronous FIFO with push/pop/count/head outputs and async active-high reset.

Test Plan:
- Reset mid-burst:
  - Stimulus: push two LU results, assert rst for one cycle.
  - Required: buf_count = 0, busy_regs = 0, rf_wr_en = 0, lu_ready = 1 immediately.
- Idle LU drain:
  - Stimulus: iss_valid reg 3; later lu_valid reg 3 data 0xBEEF; pipe idle.
  - Required: busy_regs = 0x08 until write; rf_wr_en with reg 3/0xBEEF two cycles after accept; busy_regs = 0x00 same edge.
- Pipe priority:
  - Stimulus: LU entry buffered; pipe writes reg 1 = 0x0011 then reg 2 = 0x0022 on consecutive cycles, then idles.
  - Required: rf writes are r1, r2, then the LU entry; starve_cnt reaches 2; no stall.
- Starvation:
  - Stimulus: LU entry buffered; pipe_wr_en held high continuously with STARVE_LIMIT = 4.
  - Required: four pipe writes, then pipe_stall = 1 for exactly one cycle, LU entry written, and the pipe write presented during the stall is written the following cycle.
- Full buffer:
  - Stimulus: with DEPTH = 2 and pipe saturating, push two entries.
  - Required: lu_ready = 0; a third lu_valid is held off until a pop, then accepted; FIFO order is preserved.
- Scoreboard set/clear collision:
  - Stimulus: head for reg 5 pops in the same cycle iss_valid targets reg 5 (legal re-issue after retire).
  - Required: busy_regs[5] remains 1.
